// File: rtl/cache_fill_fsm_if.sv
// Handshake bundle between the cache, the block-fill controller and memory4c.
// The master modport is the fill controller; the slave modport is its environment.
interface cache_fill_fsm_if #(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8
);
  localparam int unsigned OFF_W = $clog2(WORDS_PER_BLOCK);

  // cache -> controller
  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  // memory4c -> controller
  logic                  memory_data_valid;
  logic [15:0]           memory_data;
  // controller -> cache / memory4c
  logic                  fsm_busy;
  logic                  memory_enable;
  logic                  memory_wr;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic [15:0]           fill_data;
  logic [OFF_W-1:0]      fill_word_offset;
  logic                  write_data_array;
  logic                  write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_enable, memory_wr, memory_address,
           fill_data, fill_word_offset, write_data_array, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, memory_enable, memory_wr, memory_address,
           fill_data, fill_word_offset, write_data_array, write_tag_array
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Block-fill controller: on a cache miss, issues one word read per cycle for the
// whole aligned block, steers each returned word into the data array as memory
// data_valid pulses arrive, and writes the tag alongside the final word.
// Completion is driven by counting returned words, so any memory latency works.
module cache_fill_fsm #(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input logic              clk,
  input logic              rst,
  cache_fill_fsm_if.master bus
);
  localparam int unsigned           OFF_W      = $clog2(WORDS_PER_BLOCK);
  localparam logic [OFF_W-1:0]      LAST_WORD  = OFF_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [OFF_W-1:0]      issue_cnt;
  logic [OFF_W-1:0]      recv_cnt;
  logic                  mem_en;
  logic                  busy;

  logic                  receiving;
  logic                  data_hit;
  logic                  last_hit;
  logic [OFF_W-1:0]      next_issue;
  logic [ADDR_WIDTH-1:0] aligned_miss;

  // Receive qualifiers and address helpers derived from current state.
  always_comb begin
    receiving    = (state == ISSUE) || (state == WAIT);
    data_hit     = receiving && bus.memory_data_valid;
    last_hit     = data_hit && (recv_cnt == LAST_WORD);
    next_issue   = issue_cnt + OFF_W'(1);
    aligned_miss = bus.miss_address & ALIGN_MASK;
  end

  // Fill sequencing: request issue, word counting and registered request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_addr <= '0;
      mem_addr  <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      mem_en    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.miss_detected) begin
            base_addr <= aligned_miss;
            mem_addr  <= aligned_miss;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          issue_cnt <= next_issue;
          if (issue_cnt == LAST_WORD) begin
            // Last request is out; address holds for the remainder of the fill.
            mem_en <= 1'b0;
            state  <= WAIT;
          end else begin
            // Block is aligned, so the word offset never carries into the tag bits.
            mem_addr <= base_addr + ADDR_WIDTH'({next_issue, 1'b0});
          end
        end
        WAIT: begin
        end
        default: begin
          mem_en <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase

      // Returned words are counted; the final one ends the fill on this edge.
      if (data_hit) begin
        recv_cnt <= recv_cnt + OFF_W'(1);
        if (last_hit) begin
          mem_en <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      end
    end
  end

  // Request side comes straight from registers; write strobes follow data_valid
  // in the same cycle so the data array captures memory_data as it arrives.
  assign bus.fsm_busy         = busy;
  assign bus.memory_enable    = mem_en;
  assign bus.memory_wr        = 1'b0;
  assign bus.memory_address   = mem_addr;
  assign bus.fill_data        = bus.memory_data;
  assign bus.fill_word_offset = recv_cnt;
  assign bus.write_data_array = data_hit;
  assign bus.write_tag_array  = last_hit;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-stage memory4c-style read pipe.
// Cycle k of a fill is the clock period after the edge that samples the miss.
module tb_cache_fill_fsm;
  localparam int unsigned AW  = 16;
  localparam int unsigned WPB = 8;
  localparam logic [15:0] DATA_KEY = 16'h5A3C;

  logic clk = 1'b0;
  logic rst;
  logic noise_valid;

  int n_cmp = 0;
  int n_err = 0;

  cache_fill_fsm_if #(.ADDR_WIDTH(AW), .WORDS_PER_BLOCK(WPB)) bus ();

  cache_fill_fsm #(.ADDR_WIDTH(AW), .WORDS_PER_BLOCK(WPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears four cycles after the request cycle.
  logic [3:0]  pipe_v;
  logic [15:0] pipe_d [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < 4; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v    <= {pipe_v[2:0], bus.memory_enable & ~bus.memory_wr};
      pipe_d[0] <= bus.memory_address ^ DATA_KEY;
      pipe_d[1] <= pipe_d[0];
      pipe_d[2] <= pipe_d[1];
      pipe_d[3] <= pipe_d[2];
    end
  end

  assign bus.memory_data_valid = pipe_v[3] | noise_valid;
  assign bus.memory_data       = pipe_d[3];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, " busy"},   32'(bus.fsm_busy),         32'd0);
    check_val({tag, " en"},     32'(bus.memory_enable),    32'd0);
    check_val({tag, " wr"},     32'(bus.memory_wr),        32'd0);
    check_val({tag, " addr"},   32'(bus.memory_address),   32'd0);
    check_val({tag, " off"},    32'(bus.fill_word_offset), 32'd0);
    check_val({tag, " wda"},    32'(bus.write_data_array), 32'd0);
    check_val({tag, " wta"},    32'(bus.write_tag_array),  32'd0);
  endtask

  // One full fill, checked cycle by cycle against the expected timeline.
  // noise: hold miss and move miss_address to 0x8000 in cycle 3.
  // chain: raise the next miss in cycle 12, alongside the tag write.
  task automatic run_fill(input logic [15:0] addr, input logic [15:0] base,
                          input bit noise, input bit chain, input logic [15:0] chain_addr);
    logic [15:0] exp_addr;
    logic [15:0] word_addr;
    string t;
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    @(posedge clk);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      t = $sformatf("fill %h c%0d", base, c);
      exp_addr  = (c <= 8) ? base + 16'(2 * (c - 1)) : base + 16'd14;
      word_addr = base + 16'(2 * (c - 5));
      check_val({t, " busy"}, 32'(bus.fsm_busy),         32'(c <= 12));
      check_val({t, " en"},   32'(bus.memory_enable),    32'(c <= 8));
      check_val({t, " wr"},   32'(bus.memory_wr),        32'd0);
      if (c <= 12)
        check_val({t, " addr"}, 32'(bus.memory_address), 32'(exp_addr));
      check_val({t, " wda"},  32'(bus.write_data_array), 32'(c >= 5 && c <= 12));
      check_val({t, " wta"},  32'(bus.write_tag_array),  32'(c == 12));
      if (c <= 4)
        check_val({t, " off"}, 32'(bus.fill_word_offset), 32'd0);
      else if (c <= 12) begin
        check_val({t, " off"},  32'(bus.fill_word_offset), 32'(c - 5));
        check_val({t, " data"}, 32'(bus.fill_data),        32'(word_addr ^ DATA_KEY));
      end
      if (noise) begin
        if (c == 3) bus.miss_address = 16'h8000;
        if (c == 4) bus.miss_detected = 1'b0;
      end else if (c == 1) begin
        bus.miss_detected = 1'b0;
      end
      if (chain && c == 12) begin
        bus.miss_detected = 1'b1;
        bus.miss_address  = chain_addr;
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst               = 1'b1;
    noise_valid       = 1'b0;
    bus.miss_detected = 1'b0;
    bus.miss_address  = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle after reset");

    // Basic fill from a mid-block address.
    run_fill(16'h1236, 16'h1230, 1'b0, 1'b0, 16'h0000);

    // Miss held and re-addressed during the fill, then a back-to-back miss.
    run_fill(16'h1236, 16'h1230, 1'b1, 1'b1, 16'h4A08);
    run_fill(16'h4A08, 16'h4A00, 1'b0, 1'b0, 16'h0000);

    // Abort: asynchronous reset in the middle of cycle 7.
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h1236;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) bus.miss_detected = 1'b0;
    end
    check_val("abort pre wda", 32'(bus.write_data_array), 32'd1);
    check_val("abort pre off", 32'(bus.fill_word_offset), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_all_zero("abort");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val($sformatf("post abort c%0d wta", c), 32'(bus.write_tag_array),  32'd0);
      check_val($sformatf("post abort c%0d wda", c), 32'(bus.write_data_array), 32'd0);
      check_val($sformatf("post abort c%0d busy", c), 32'(bus.fsm_busy),        32'd0);
    end
    run_fill(16'h0010, 16'h0010, 1'b0, 1'b0, 16'h0000);

    // Stray data_valid while idle must not strobe anything.
    noise_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val($sformatf("idle noise c%0d wda", c),  32'(bus.write_data_array), 32'd0);
      check_val($sformatf("idle noise c%0d wta", c),  32'(bus.write_tag_array),  32'd0);
      check_val($sformatf("idle noise c%0d busy", c), 32'(bus.fsm_busy),         32'd0);
    end
    noise_valid = 1'b0;

    // Top of memory: block 0xFFF0..0xFFFE with no wrap.
    run_fill(16'hFFF6, 16'hFFF0, 1'b0, 1'b0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
